// File: rtl/or1k_branch_resolver.sv
// Execute-side branch resolution: tracks decode-stage predictions in order, checks them
// against the resolved flag and holds the corrected fetch PC until fetch acknowledges it.
module or1k_branch_resolver #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int DEPTH                = 2,
  parameter     FEATURE_DELAY_SLOT   = "ENABLED",
  parameter int CNT_WIDTH            = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_decode_i,
  input  logic                            decode_op_bf_i,
  input  logic                            decode_op_bnf_i,
  input  logic                            predicted_flag_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] decode_target_i,
  input  logic                            padv_execute_i,
  input  logic                            execute_op_brcond_i,
  input  logic                            flag_i,
  input  logic                            fetch_redirect_ack_i,
  output logic                            queue_full_o,
  output logic                            branch_mispredict_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
  output logic                            prev_op_brcond_o,
  output logic                            prev_brn_taken_o,
  output logic [CNT_WIDTH-1:0]            mispredict_count_o,
  output logic                            resolve_error_o
);

  localparam int W  = OPTION_OPERAND_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [W-1:0] FT_OFS = (FEATURE_DELAY_SLOT == "ENABLED") ? W'(8) : W'(4);

  typedef enum logic {TRACK, RECOVER} state_t;

  state_t         state;
  logic           ent_bf     [DEPTH];
  logic           ent_pred   [DEPTH];
  logic [W-1:0]   ent_target [DEPTH];
  logic [W-1:0]   ent_ft     [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;

  logic is_track;
  logic push_req;
  logic push;
  logic pop;
  logic empty_resolve;
  logic head_taken;
  logic mismatch;

  always_comb begin
    is_track      = (state == TRACK);
    queue_full_o  = (count == CW'(DEPTH));
    push_req      = padv_decode_i & (decode_op_bf_i | decode_op_bnf_i) & is_track;
    pop           = padv_execute_i & execute_op_brcond_i & is_track & (count != '0);
    empty_resolve = padv_execute_i & execute_op_brcond_i & is_track & (count == '0);
    head_taken    = ent_bf[rd_ptr] ? flag_i : ~flag_i;
    mismatch      = pop & (head_taken != ent_pred[rd_ptr]);
    // A push alongside a pop always fits; a push that races a mispredict is wrong-path.
    push          = push_req & ~mismatch & (~queue_full_o | pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_bf[wr_ptr]     <= decode_op_bf_i;
      ent_pred[wr_ptr]   <= predicted_flag_i;
      ent_target[wr_ptr] <= decode_target_i;
      ent_ft[wr_ptr]     <= decode_pc_i + FT_OFS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= TRACK;
      rd_ptr              <= '0;
      wr_ptr              <= '0;
      count               <= '0;
      branch_mispredict_o <= 1'b0;
      redirect_pc_o       <= '0;
      prev_op_brcond_o    <= 1'b0;
      prev_brn_taken_o    <= 1'b0;
      mispredict_count_o  <= '0;
      resolve_error_o     <= 1'b0;
    end else begin
      prev_op_brcond_o <= pop;
      prev_brn_taken_o <= pop & head_taken;
      if (empty_resolve)
        resolve_error_o <= 1'b1;

      if (mismatch) begin
        state               <= RECOVER;
        branch_mispredict_o <= 1'b1;
        redirect_pc_o       <= head_taken ? ent_target[rd_ptr] : ent_ft[rd_ptr];
        rd_ptr              <= '0;
        wr_ptr              <= '0;
        count               <= '0;
        if (mispredict_count_o != '1)
          mispredict_count_o <= mispredict_count_o + 1'b1;
      end else begin
        if (state == RECOVER && fetch_redirect_ack_i) begin
          state               <= TRACK;
          branch_mispredict_o <= 1'b0;
          redirect_pc_o       <= '0;
        end
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)
          count <= count + 1'b1;
        else if (pop && !push)
          count <= count - 1'b1;
      end
    end
  end

endmodule
